// File: rtl/kronos_lsu_wb_pkg.sv
// +----------------------------------------------------------------------------+
// | kronos_types : shared load/store size encodings and write-back FSM states  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package kronos_types;

    localparam logic [2:0] BYTE  = 3'b000;
    localparam logic [2:0] HALF  = 3'b001;
    localparam logic [2:0] WORD  = 3'b010;
    localparam logic [2:0] BYTEU = 3'b100;
    localparam logic [2:0] HALFU = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEM  = 1'b1
    } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/kronos_lsu_wb_load_align.sv
// +----------------------------------------------------------------------------+
// | kronos_load_align : lane-select and sign/zero-extend raw bus read data     |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module kronos_load_align
    import kronos_types::*;
(
    input  logic [31:0] rd_data,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] w_shifted;

    // Shift the addressed byte lane down to bit 0 before extension
    assign w_shifted = rd_data >> {off, 3'b000};

    always_comb begin
        data = rd_data;
        case (funct3)
            BYTE:    data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            BYTEU:   data = {24'h0, w_shifted[7:0]};
            HALF:    data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            HALFU:   data = {16'h0, w_shifted[15:0]};
            default: data = rd_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/kronos_lsu_wb.sv
// +----------------------------------------------------------------------------+
// | kronos_lsu_wb : write-back stage, performs data-bus loads/stores and       |
// |                 drives the register file write port                        |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module kronos_lsu_wb
    import kronos_types::*;
#(
    parameter bit CATCH_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rstz,

    input  logic        exec_vld,
    output logic        exec_rdy,
    input  logic [31:0] exec_result,
    input  logic [4:0]  exec_rd,
    input  logic        exec_rd_write,
    input  logic        exec_load,
    input  logic        exec_store,
    input  logic [2:0]  exec_funct3,
    input  logic [31:0] exec_store_data,

    output logic [31:0] data_addr,
    output logic        data_req,
    output logic        data_wr_en,
    output logic [31:0] data_wr_data,
    output logic [3:0]  data_mask,
    input  logic [31:0] data_rd_data,
    input  logic        data_ack,

    output logic [31:0] regwr_data,
    output logic [4:0]  regwr_sel,
    output logic        regwr_en,
    output logic        ls_misaligned
);

    lsu_state_e  state_q, state_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic        data_req_q, data_req_d;
    logic        data_wr_en_q, data_wr_en_d;
    logic [31:0] data_wr_data_q, data_wr_data_d;
    logic [3:0]  data_mask_q, data_mask_d;
    logic [31:0] regwr_data_q, regwr_data_d;
    logic [4:0]  regwr_sel_q, regwr_sel_d;
    logic        regwr_en_q, regwr_en_d;
    logic        misaligned_q, misaligned_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        load_q, load_d;

    logic [1:0]  w_off;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_misaligned;
    logic [1:0]  w_lane_off;
    logic [3:0]  w_mask;
    logic [31:0] w_wr_data;
    logic [31:0] w_aligned;

    assign w_off     = exec_result[1:0];
    assign w_is_byte = (exec_funct3[1:0] == 2'b00);
    assign w_is_half = (exec_funct3[1:0] == 2'b01);

    assign w_misaligned = CATCH_MISALIGNED &&
                          ((w_is_half && (w_off == 2'b11)) ||
                           (!w_is_byte && !w_is_half && (w_off != 2'b00)));

    // Without trapping, offset bits finer than the access size are dropped
    always_comb begin
        w_lane_off = w_off;
        if (!CATCH_MISALIGNED) begin
            if (w_is_half)       w_lane_off = {w_off[1], 1'b0};
            else if (!w_is_byte) w_lane_off = 2'b00;
        end
    end

    always_comb begin
        if (w_is_byte) begin
            w_mask    = 4'b0001 << w_lane_off;
            w_wr_data = {4{exec_store_data[7:0]}};
        end else if (w_is_half) begin
            w_mask    = 4'b0011 << w_lane_off;
            w_wr_data = {2{exec_store_data[15:0]}};
        end else begin
            w_mask    = 4'b1111;
            w_wr_data = exec_store_data;
        end
    end

    kronos_load_align u_load_align (
        .rd_data (data_rd_data),
        .off     (off_q),
        .funct3  (funct3_q),
        .data    (w_aligned)
    );

    assign exec_rdy = (state_q == IDLE);

    always_comb begin
        state_d        = state_q;
        data_addr_d    = data_addr_q;
        data_req_d     = data_req_q;
        data_wr_en_d   = data_wr_en_q;
        data_wr_data_d = data_wr_data_q;
        data_mask_d    = data_mask_q;
        regwr_data_d   = regwr_data_q;
        regwr_sel_d    = regwr_sel_q;
        regwr_en_d     = 1'b0;
        misaligned_d   = 1'b0;
        off_d          = off_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        load_d         = load_q;

        case (state_q)
            IDLE: begin
                if (exec_vld) begin
                    if (exec_load || exec_store) begin
                        if (w_misaligned) begin
                            misaligned_d = 1'b1;
                        end else begin
                            state_d        = MEM;
                            data_req_d     = 1'b1;
                            data_wr_en_d   = exec_store;
                            data_addr_d    = {exec_result[31:2], 2'b00};
                            data_mask_d    = w_mask;
                            data_wr_data_d = w_wr_data;
                            off_d          = w_lane_off;
                            funct3_d       = exec_funct3;
                            rd_d           = exec_rd;
                            load_d         = exec_load;
                        end
                    end else begin
                        regwr_data_d = exec_result;
                        regwr_sel_d  = exec_rd;
                        regwr_en_d   = exec_rd_write && (exec_rd != 5'd0);
                    end
                end
            end
            MEM: begin
                if (data_ack) begin
                    state_d      = IDLE;
                    data_req_d   = 1'b0;
                    data_wr_en_d = 1'b0;
                    if (load_q && (rd_q != 5'd0)) begin
                        regwr_en_d   = 1'b1;
                        regwr_data_d = w_aligned;
                        regwr_sel_d  = rd_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q        <= IDLE;
            data_addr_q    <= 32'h0;
            data_req_q     <= 1'b0;
            data_wr_en_q   <= 1'b0;
            data_wr_data_q <= 32'h0;
            data_mask_q    <= 4'h0;
            regwr_data_q   <= 32'h0;
            regwr_sel_q    <= 5'd0;
            regwr_en_q     <= 1'b0;
            misaligned_q   <= 1'b0;
            off_q          <= 2'b00;
            funct3_q       <= 3'b000;
            rd_q           <= 5'd0;
            load_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            data_addr_q    <= data_addr_d;
            data_req_q     <= data_req_d;
            data_wr_en_q   <= data_wr_en_d;
            data_wr_data_q <= data_wr_data_d;
            data_mask_q    <= data_mask_d;
            regwr_data_q   <= regwr_data_d;
            regwr_sel_q    <= regwr_sel_d;
            regwr_en_q     <= regwr_en_d;
            misaligned_q   <= misaligned_d;
            off_q          <= off_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            load_q         <= load_d;
        end
    end

    assign data_addr     = data_addr_q;
    assign data_req      = data_req_q;
    assign data_wr_en    = data_wr_en_q;
    assign data_wr_data  = data_wr_data_q;
    assign data_mask     = data_mask_q;
    assign regwr_data    = regwr_data_q;
    assign regwr_sel     = regwr_sel_q;
    assign regwr_en      = regwr_en_q;
    assign ls_misaligned = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_kronos_lsu_wb.sv
// +----------------------------------------------------------------------------+
// | tb_kronos_lsu_wb : scoreboard bench for the Kronos write-back stage        |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_kronos_lsu_wb;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic        exec_vld = 1'b0;
    logic        exec_rdy;
    logic [31:0] exec_result = 32'h0;
    logic [4:0]  exec_rd = 5'd0;
    logic        exec_rd_write = 1'b0;
    logic        exec_load = 1'b0;
    logic        exec_store = 1'b0;
    logic [2:0]  exec_funct3 = 3'b000;
    logic [31:0] exec_store_data = 32'h0;
    logic [31:0] data_addr;
    logic        data_req;
    logic        data_wr_en;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic [31:0] data_rd_data = 32'h0;
    logic        data_ack = 1'b0;
    logic [31:0] regwr_data;
    logic [4:0]  regwr_sel;
    logic        regwr_en;
    logic        ls_misaligned;

    int checks = 0;
    int failures = 0;
    logic [36:0] sb[$];

    kronos_lsu_wb #(.CATCH_MISALIGNED(1'b1)) dut (
        .clk             (clk),
        .rstz            (rstz),
        .exec_vld        (exec_vld),
        .exec_rdy        (exec_rdy),
        .exec_result     (exec_result),
        .exec_rd         (exec_rd),
        .exec_rd_write   (exec_rd_write),
        .exec_load       (exec_load),
        .exec_store      (exec_store),
        .exec_funct3     (exec_funct3),
        .exec_store_data (exec_store_data),
        .data_addr       (data_addr),
        .data_req        (data_req),
        .data_wr_en      (data_wr_en),
        .data_wr_data    (data_wr_data),
        .data_mask       (data_mask),
        .data_rd_data    (data_rd_data),
        .data_ack        (data_ack),
        .regwr_data      (regwr_data),
        .regwr_sel       (regwr_sel),
        .regwr_en        (regwr_en),
        .ls_misaligned   (ls_misaligned)
    );

    always #5 clk = ~clk;

    // Every write pulse must match the oldest expected write-back
    always @(negedge clk) begin
        if (rstz && regwr_en) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected got sel=%0d data=%h required no write", regwr_sel, regwr_data);
            end else begin
                logic [36:0] exp_wb;
                exp_wb = sb.pop_front();
                if ({regwr_sel, regwr_data} !== exp_wb) begin
                    failures++;
                    $display("FAIL wb_data got sel=%0d data=%h required sel=%0d data=%h",
                             regwr_sel, regwr_data, exp_wb[36:32], exp_wb[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] res, input logic [4:0] rd, input logic rdw,
                         input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] sd);
        exec_result     = res;
        exec_rd         = rd;
        exec_rd_write   = rdw;
        exec_load       = ld;
        exec_store      = st;
        exec_funct3     = f3;
        exec_store_data = sd;
        exec_vld        = 1'b1;
        @(posedge clk); #1;
        exec_vld   = 1'b0;
        exec_load  = 1'b0;
        exec_store = 1'b0;
    endtask

    task automatic bus_ack(input logic [31:0] rdata);
        data_rd_data = rdata;
        data_ack     = 1'b1;
        @(posedge clk); #1;
        data_ack     = 1'b0;
        data_rd_data = 32'h0;
    endtask

    task automatic test_reset;
        checks++;
        if ({data_req, data_wr_en, regwr_en, ls_misaligned} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got %b required 0000", {data_req, data_wr_en, regwr_en, ls_misaligned});
        end
        checks++;
        if ({data_addr, data_wr_data, regwr_data} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data got %h %h %h required zeros", data_addr, data_wr_data, regwr_data);
        end
        checks++;
        if ({data_mask, regwr_sel} !== 9'h0) begin
            failures++;
            $display("FAIL reset_mask_sel got %h %h required 0 0", data_mask, regwr_sel);
        end
        checks++;
        if (exec_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_rdy got %b required 1", exec_rdy);
        end
    endtask

    task automatic test_alu_stream;
        sb.push_back({5'd5, 32'h1111_0005});
        sb.push_back({5'd6, 32'h2222_0006});
        issue(32'h1111_0005, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0);
        checks++;
        if ({regwr_en, regwr_sel} !== {1'b1, 5'd5}) begin
            failures++;
            $display("FAIL alu_first got en=%b sel=%0d required en=1 sel=5", regwr_en, regwr_sel);
        end
        issue(32'h2222_0006, 5'd6, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0);
        checks++;
        if ({regwr_en, regwr_sel} !== {1'b1, 5'd6}) begin
            failures++;
            $display("FAIL alu_second got en=%b sel=%0d required en=1 sel=6", regwr_en, regwr_sel);
        end
        issue(32'h3333_0000, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0);
        checks++;
        if (regwr_en !== 1'b0) begin
            failures++;
            $display("FAIL alu_x0 got en=%b required 0", regwr_en);
        end
        issue(32'h4444_0007, 5'd7, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        checks++;
        if (regwr_en !== 1'b0) begin
            failures++;
            $display("FAIL alu_no_rd_write got en=%b required 0", regwr_en);
        end
    endtask

    task automatic test_lb_wait;
        sb.push_back({5'd7, 32'hFFFF_FF80});
        issue(32'h0000_1003, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0);
        checks++;
        if ({data_req, data_wr_en, exec_rdy, data_addr} !== {3'b100, 32'h0000_1000}) begin
            failures++;
            $display("FAIL lb_issue got req=%b we=%b rdy=%b addr=%h required 1 0 0 00001000",
                     data_req, data_wr_en, exec_rdy, data_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({data_req, exec_rdy, regwr_en, data_addr} !== {3'b100, 32'h0000_1000}) begin
                failures++;
                $display("FAIL lb_hold cycle %0d got req=%b rdy=%b en=%b addr=%h required 1 0 0 00001000",
                         i, data_req, exec_rdy, regwr_en, data_addr);
            end
        end
        bus_ack(32'h80FF_1234);
        checks++;
        if ({data_req, regwr_en, exec_rdy, regwr_data} !== {3'b011, 32'hFFFF_FF80}) begin
            failures++;
            $display("FAIL lb_done got req=%b en=%b rdy=%b data=%h required 0 1 1 ffffff80",
                     data_req, regwr_en, exec_rdy, regwr_data);
        end
    endtask

    task automatic test_load_ext;
        sb.push_back({5'd8, 32'h0000_BEEF});
        issue(32'h0000_2002, 5'd8, 1'b1, 1'b1, 1'b0, 3'b101, 32'h0);
        bus_ack(32'hBEEF_0000);
        sb.push_back({5'd9, 32'hFFFF_BEEF});
        issue(32'h0000_2002, 5'd9, 1'b1, 1'b1, 1'b0, 3'b001, 32'h0);
        bus_ack(32'hBEEF_0000);
        sb.push_back({5'd10, 32'h1234_5678});
        issue(32'h0000_4000, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0);
        checks++;
        if (regwr_en !== 1'b0) begin
            failures++;
            $display("FAIL lw_early got en=%b required 0", regwr_en);
        end
        bus_ack(32'h1234_5678);
        checks++;
        if ({regwr_en, regwr_sel, regwr_data} !== {1'b1, 5'd10, 32'h1234_5678}) begin
            failures++;
            $display("FAIL lw_latency got en=%b sel=%0d data=%h required 1 10 12345678",
                     regwr_en, regwr_sel, regwr_data);
        end
        issue(32'h0000_4004, 5'd0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0);
        bus_ack(32'hAAAA_5555);
        checks++;
        if ({regwr_en, data_req} !== 2'b00) begin
            failures++;
            $display("FAIL lw_x0 got en=%b req=%b required 0 0", regwr_en, data_req);
        end
    endtask

    task automatic test_store;
        issue(32'h0000_3001, 5'd5, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_00AB);
        checks++;
        if ({data_req, data_wr_en, data_mask, data_wr_data, data_addr} !==
            {2'b11, 4'b0010, 32'hABAB_ABAB, 32'h0000_3000}) begin
            failures++;
            $display("FAIL sb_bus got req=%b we=%b mask=%b wd=%h addr=%h required 1 1 0010 abababab 00003000",
                     data_req, data_wr_en, data_mask, data_wr_data, data_addr);
        end
        bus_ack(32'h0);
        checks++;
        if ({data_req, regwr_en} !== 2'b00) begin
            failures++;
            $display("FAIL sb_done got req=%b en=%b required 0 0", data_req, regwr_en);
        end
        issue(32'h0000_3002, 5'd6, 1'b0, 1'b0, 1'b1, 3'b001, 32'h9999_CDEF);
        checks++;
        if ({data_wr_en, data_mask, data_wr_data} !== {1'b1, 4'b1100, 32'hCDEF_CDEF}) begin
            failures++;
            $display("FAIL sh_bus got we=%b mask=%b wd=%h required 1 1100 cdefcdef",
                     data_wr_en, data_mask, data_wr_data);
        end
        bus_ack(32'h0);
        issue(32'h0000_3004, 5'd7, 1'b0, 1'b0, 1'b1, 3'b010, 32'hDEAD_BEEF);
        checks++;
        if ({data_mask, data_wr_data, data_addr} !== {4'b1111, 32'hDEAD_BEEF, 32'h0000_3004}) begin
            failures++;
            $display("FAIL sw_bus got mask=%b wd=%h addr=%h required 1111 deadbeef 00003004",
                     data_mask, data_wr_data, data_addr);
        end
        bus_ack(32'h0);
    endtask

    task automatic test_misaligned;
        issue(32'h0000_4001, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0);
        checks++;
        if ({ls_misaligned, data_req, exec_rdy, regwr_en} !== 4'b1010) begin
            failures++;
            $display("FAIL mis_lw got mis=%b req=%b rdy=%b en=%b required 1 0 1 0",
                     ls_misaligned, data_req, exec_rdy, regwr_en);
        end
        @(posedge clk); #1;
        checks++;
        if ({ls_misaligned, data_req, regwr_en} !== 3'b000) begin
            failures++;
            $display("FAIL mis_pulse got mis=%b req=%b en=%b required 0 0 0",
                     ls_misaligned, data_req, regwr_en);
        end
        issue(32'h0000_3003, 5'd3, 1'b0, 1'b0, 1'b1, 3'b001, 32'h1234_5678);
        checks++;
        if ({ls_misaligned, data_req, exec_rdy} !== 3'b101) begin
            failures++;
            $display("FAIL mis_sh got mis=%b req=%b rdy=%b required 1 0 1",
                     ls_misaligned, data_req, exec_rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mem;
        issue(32'h0000_5000, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0);
        @(negedge clk); #2;
        rstz = 1'b0;
        #1;
        checks++;
        if ({data_req, exec_rdy, regwr_en} !== 3'b010) begin
            failures++;
            $display("FAIL rst_mem got req=%b rdy=%b en=%b required 0 1 0", data_req, exec_rdy, regwr_en);
        end
        @(posedge clk); #1;
        rstz = 1'b1;
        bus_ack(32'h7777_7777);
        checks++;
        if ({data_req, regwr_en, exec_rdy} !== 3'b001) begin
            failures++;
            $display("FAIL rst_late_ack got req=%b en=%b rdy=%b required 0 0 1", data_req, regwr_en, exec_rdy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        sb.push_back({5'd12, 32'h0000_0056});
        sb.push_back({5'd13, 32'hCAFE_F00D});
        issue(32'h0000_6001, 5'd12, 1'b1, 1'b1, 1'b0, 3'b100, 32'h0);
        bus_ack(32'h0000_5600);
        checks++;
        if ({regwr_en, regwr_sel, exec_rdy} !== {1'b1, 5'd12, 1'b1}) begin
            failures++;
            $display("FAIL b2b_load got en=%b sel=%0d rdy=%b required 1 12 1", regwr_en, regwr_sel, exec_rdy);
        end
        issue(32'hCAFE_F00D, 5'd13, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0);
        checks++;
        if ({regwr_en, regwr_sel} !== {1'b1, 5'd13}) begin
            failures++;
            $display("FAIL b2b_alu got en=%b sel=%0d required 1 13", regwr_en, regwr_sel);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        test_reset;
        rstz = 1'b1;
        @(posedge clk); #1;
        test_alu_stream;
        @(posedge clk); #1;
        test_lb_wait;
        test_load_ext;
        test_store;
        test_misaligned;
        test_reset_mid_mem;
        test_back_to_back;
        @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d pending write-backs required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
